// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage core: E-stage forwarding, load-use stalls, branch flushes,
// a data-memory wait FSM with timeout, and saturating stall/flush counters.
module hazard_ctrl #(
   parameter int unsigned MaxWait = 16,
   parameter int unsigned CntW    = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [4:0]      rs1_d_i,
   input  logic [4:0]      rs2_d_i,
   input  logic [4:0]      rs1_e_i,
   input  logic [4:0]      rs2_e_i,
   input  logic [4:0]      rd_e_i,
   input  logic            load_e_i,
   input  logic            pc_src_e_i,
   input  logic [4:0]      rd_m_i,
   input  logic [4:0]      rd_w_i,
   input  logic            reg_write_m_i,
   input  logic            reg_write_w_i,
   input  logic            mem_req_m_i,
   input  logic            mem_ready_m_i,
   output logic            stall_f_o,
   output logic            stall_d_o,
   output logic            stall_e_o,
   output logic            stall_m_o,
   output logic            flush_d_o,
   output logic            flush_e_o,
   output logic [1:0]      forward_a_e_o,
   output logic [1:0]      forward_b_e_o,
   output logic            mem_err_o,
   output logic [CntW-1:0] stall_cnt_o,
   output logic [CntW-1:0] flush_cnt_o
);

   localparam int unsigned WaitW = (MaxWait > 1) ? $clog2(MaxWait + 1) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

   state_e            state_q, state_d;
   logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
   logic [CntW-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CntW-1:0]   flush_cnt_q, flush_cnt_d;
   logic              lw, ms, stall_any, flush_any;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                          input logic we_m, input logic [4:0] rd_w,
                                          input logic we_w);
      if (we_m && rd_m != 5'd0 && rd_m == rs) begin
         return 2'b10;
      end else if (we_w && rd_w != 5'd0 && rd_w == rs) begin
         return 2'b01;
      end
      return 2'b00;
   endfunction

   assign lw = load_e_i && rd_e_i != 5'd0 && (rd_e_i == rs1_d_i || rd_e_i == rs2_d_i);

   // The IDLE detect cycle is the first not-ready cycle, so the count starts at 1 there.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      ms         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mem_req_m_i && !mem_ready_m_i) begin
               ms         = 1'b1;
               wait_cnt_d = WaitW'(1);
               state_d    = (MaxWait == 1) ? StErr : StWait;
            end
         end
         StWait: begin
            if (mem_ready_m_i) begin
               state_d    = StIdle;
               wait_cnt_d = '0;
            end else begin
               ms = 1'b1;
               if (MaxWait != 0) begin
                  if (32'(wait_cnt_q) + 32'd1 >= MaxWait) begin
                     state_d = StErr;
                  end else begin
                     wait_cnt_d = wait_cnt_q + 1'b1;
                  end
               end
            end
         end
         StErr:   ms = 1'b1;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are forced inactive while reset is asserted, without waiting for a clock.
   always_comb begin
      stall_f_o     = 1'b0;
      stall_d_o     = 1'b0;
      stall_e_o     = 1'b0;
      stall_m_o     = 1'b0;
      flush_d_o     = 1'b0;
      flush_e_o     = 1'b0;
      forward_a_e_o = 2'b00;
      forward_b_e_o = 2'b00;
      if (rst_ni) begin
         forward_a_e_o = fwd_sel(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
         forward_b_e_o = fwd_sel(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
         if (ms) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            stall_e_o = 1'b1;
            stall_m_o = 1'b1;
         end else begin
            stall_f_o = lw && !pc_src_e_i;
            stall_d_o = lw && !pc_src_e_i;
            flush_d_o = pc_src_e_i;
            flush_e_o = lw || pc_src_e_i;
         end
      end
   end

   assign stall_any   = stall_f_o | stall_d_o | stall_e_o | stall_m_o;
   assign flush_any   = flush_d_o | flush_e_o;
   assign stall_cnt_d = (stall_any && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   assign flush_cnt_d = (flush_any && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign mem_err_o   = (state_q == StErr);
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance plus a MaxWait=4 / CntW=4 instance
// sharing the same stimulus.
module tb_hazard_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic       load_e, pc_src_e, reg_write_m, reg_write_w, mem_req_m, mem_ready_m;

   logic        sf, sd, se, sm, fd, fe, merr;
   logic [1:0]  fa, fb;
   logic [31:0] scnt, fcnt;

   logic        s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_merr;
   logic [1:0]  s_fa, s_fb;
   logic [3:0]  s_scnt, s_fcnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   hazard_ctrl u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e), .rd_e_i(rd_e),
      .load_e_i(load_e), .pc_src_e_i(pc_src_e), .rd_m_i(rd_m), .rd_w_i(rd_w),
      .reg_write_m_i(reg_write_m), .reg_write_w_i(reg_write_w),
      .mem_req_m_i(mem_req_m), .mem_ready_m_i(mem_ready_m),
      .stall_f_o(sf), .stall_d_o(sd), .stall_e_o(se), .stall_m_o(sm),
      .flush_d_o(fd), .flush_e_o(fe), .forward_a_e_o(fa), .forward_b_e_o(fb),
      .mem_err_o(merr), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
   );

   hazard_ctrl #(.MaxWait(4), .CntW(4)) u_dut_small (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e), .rd_e_i(rd_e),
      .load_e_i(load_e), .pc_src_e_i(pc_src_e), .rd_m_i(rd_m), .rd_w_i(rd_w),
      .reg_write_m_i(reg_write_m), .reg_write_w_i(reg_write_w),
      .mem_req_m_i(mem_req_m), .mem_ready_m_i(mem_ready_m),
      .stall_f_o(s_sf), .stall_d_o(s_sd), .stall_e_o(s_se), .stall_m_o(s_sm),
      .flush_d_o(s_fd), .flush_e_o(s_fe), .forward_a_e_o(s_fa), .forward_b_e_o(s_fb),
      .mem_err_o(s_merr), .stall_cnt_o(s_scnt), .flush_cnt_o(s_fcnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
      {load_e, pc_src_e, reg_write_m, reg_write_w, mem_req_m, mem_ready_m} = '0;
   endtask

   task automatic pulse_reset();
      rst_ni = 1'b0;
      #1;
      rst_ni = 1'b1;
      #1;
   endtask

   initial begin
      clear_inputs();
      rst_ni = 1'b0;
      rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1;
      load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
      #3;
      check("rst_fwd_a", 32'(fa), 32'h0);
      check("rst_stalls", 32'({sf, sd, se, sm, fd, fe}), 32'h0);
      check("rst_counters", scnt | fcnt, 32'h0);
      check("rst_mem_err", 32'(merr), 32'h0);
      step();
      rst_ni = 1'b1;
      clear_inputs();

      // Forwarding: M wins over W, RD=0 never forwards
      rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1'b1; rd_w = 5'd5; reg_write_w = 1'b1;
      #1 check("fwd_a_m_prio", 32'(fa), 32'h2);
      rd_m = 5'd0;
      #1 check("fwd_a_w", 32'(fa), 32'h1);
      rs2_e = 5'd9; rd_w = 5'd9; rd_m = 5'd9; reg_write_m = 1'b0;
      #1 check("fwd_b_w", 32'(fb), 32'h1);
      check("fwd_a_none", 32'(fa), 32'h0);
      rd_w = 5'd0; rs2_e = 5'd0; reg_write_w = 1'b1;
      #1 check("fwd_b_x0", 32'(fb), 32'h0);
      clear_inputs();

      // Load-use
      step();
      load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
      #1 check("lu_outs", 32'({sf, sd, se, sm, fd, fe}), 32'b110001);
      step();
      clear_inputs();
      check("lu_stall_cnt", scnt, 32'd1);
      check("lu_flush_cnt", fcnt, 32'd1);
      load_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0;
      #1 check("lu_x0", 32'({sf, sd, fe}), 32'h0);
      clear_inputs();

      // Branch during load-use
      load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7; pc_src_e = 1'b1;
      #1 check("br_lu_outs", 32'({sf, sd, se, sm, fd, fe}), 32'b000011);
      step();
      clear_inputs();
      check("br_stall_cnt", scnt, 32'd1);
      check("br_flush_cnt", fcnt, 32'd2);

      // Memory wait: 3 not-ready cycles, then ready; a pending branch must not flush
      mem_req_m = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pc_src_e = (i == 1);
         #1 check($sformatf("mw_stall_%0d", i), 32'({sf, sd, se, sm, fd, fe}), 32'b111100);
         step();
      end
      pc_src_e = 1'b0;
      mem_ready_m = 1'b1;
      #1 check("mw_ready", 32'({sf, sd, se, sm}), 32'h0);
      step();
      clear_inputs();
      check("mw_stall_cnt", scnt, 32'd4);
      check("mw_flush_cnt", fcnt, 32'd2);
      check("mw_no_err", 32'(merr), 32'h0);

      // Timeout on the MaxWait=4 instance
      pulse_reset();
      mem_req_m = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check("to_before", 32'(s_merr), 32'h0);
      step();
      check("to_err", 32'(s_merr), 32'h1);
      check("to_default_no_err", 32'(merr), 32'h0);
      mem_ready_m = 1'b1;
      step();
      check("to_sticky", 32'(s_merr), 32'h1);
      check("to_err_stall", 32'({s_sf, s_sm, s_fd}), 32'b110);
      check("to_default_release", 32'({sf, sm}), 32'h0);

      // Async reset mid-WAIT, then re-evaluation of the pending access
      mem_ready_m = 1'b0;
      step();
      check("ar_waiting", 32'({sf, sm}), 32'b11);
      rst_ni = 1'b0;
      #1;
      check("ar_outs", 32'({sf, sd, se, sm, s_sf, s_sm}), 32'h0);
      check("ar_err_clr", 32'(s_merr), 32'h0);
      check("ar_cnt_clr", scnt, 32'h0);
      rst_ni = 1'b1;
      #1 check("ar_reeval", 32'({sf, sm}), 32'b11);
      mem_ready_m = 1'b1;
      step();
      clear_inputs();

      // Saturation: 20 load-use cycles
      pulse_reset();
      load_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3;
      for (int i = 0; i < 20; i++) step();
      clear_inputs();
      check("sat_small_stall", 32'(s_scnt), 32'd15);
      check("sat_small_flush", 32'(s_fcnt), 32'd15);
      check("sat_default_stall", scnt, 32'd20);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got 0 expected 1");
      $fatal(1);
   end

endmodule
